// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DROP
    } fetch_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response bus between fetch (master) and memory (slave).
interface instruction_fetch_if #(
    parameter int LEN = 32
);

    logic           mem_req_valid;
    logic           mem_req_ready;
    logic [LEN-1:0] mem_addr;
    logic           mem_resp_valid;
    logic [LEN-1:0] mem_rdata;

    modport master (
        output mem_req_valid,
        output mem_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_rdata
    );

endinterface

// File: rtl/instruction_fetch_pc_register.sv
// Program counter with priority reset > redirect > increment; always word aligned.
module pc_register
    import instruction_fetch_pkg::*;
#(
    parameter int             LEN      = 32,
    parameter logic [LEN-1:0] RESET_PC = LEN'(DEFAULT_RESET_PC)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           redirect_valid,
    input  logic [LEN-1:0] redirect_pc,
    input  logic           incr,
    output logic [LEN-1:0] pc
);

    // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= {RESET_PC[LEN-1:2], 2'b00};
        end else if (en) begin
            if (redirect_valid) begin
                pc <= {redirect_pc[LEN-1:2], 2'b00};
            end else if (incr) begin
                pc <= pc + LEN'(4);
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch FSM feeding a decode stage through a held output register.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int             LEN      = 32,
    parameter logic [LEN-1:0] RESET_PC = LEN'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy_in,
    instruction_fetch_if.master mem,
    input  logic                redirect_valid,
    input  logic [LEN-1:0]      redirect_pc,
    input  logic                stall_in,
    output logic                inst_valid,
    output logic [LEN-1:0]      instruction,
    output logic [LEN-1:0]      inst_pc
);

    fetch_state_e   state, state_d;
    logic [LEN-1:0] pc;
    logic           pc_incr;
    logic           inst_valid_d;
    logic [LEN-1:0] instruction_d;
    logic [LEN-1:0] inst_pc_d;

    pc_register #(
        .LEN      (LEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk            (clk),
        .rst            (rst),
        .en             (rdy_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .incr           (pc_incr),
        .pc             (pc)
    );

    assign mem.mem_addr      = pc;
    assign mem.mem_req_valid = rst && rdy_in && (state == ST_REQ);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d       = state;
        pc_incr       = 1'b0;
        inst_valid_d  = inst_valid;
        instruction_d = instruction;
        inst_pc_d     = inst_pc;

        case (state)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = redirect_valid ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    state_d = mem.mem_resp_valid ? ST_REQ : ST_DROP;
                end else if (mem.mem_resp_valid) begin
                    instruction_d = mem.mem_rdata;
                    inst_pc_d     = pc;
                    inst_valid_d  = 1'b1;
                    pc_incr       = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            // A response for the abandoned address is swallowed before fetching again.
            ST_DROP: begin
                if (mem.mem_resp_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || !stall_in) begin
                    inst_valid_d  = 1'b0;
                    instruction_d = LEN'(NOP);
                    state_d       = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            inst_valid  <= 1'b0;
            instruction <= LEN'(NOP);
            inst_pc     <= '0;
        end else if (rdy_in) begin
            state       <= state_d;
            inst_valid  <= inst_valid_d;
            instruction <= instruction_d;
            inst_pc     <= inst_pc_d;
        end
    end

    a_no_resp_when_frozen: assert property (
        @(posedge clk) disable iff (!rst) !(mem.mem_resp_valid && !rdy_in)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed scenarios followed by randomized traffic checked against a program-order scoreboard.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_in;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_pc;

    instruction_fetch_if #(.LEN(32)) mem_if ();

    instruction_fetch #(.LEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy_in         (rdy_in),
        .mem            (mem_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_in       (stall_in),
        .inst_valid     (inst_valid),
        .instruction    (instruction),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory image used during random traffic: content is a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h9E37_79B9;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard: program-order address of the next instruction decode should consume.
    logic [31:0] exp_q[$];
    bit          random_mode = 1'b0;
    bit          outstanding = 1'b0;
    logic [31:0] out_addr;
    int          delay;
    int          consumed = 0;

    always @(negedge clk) begin
        if (random_mode && rst) begin
            if (!rdy_in) check("req_frozen", {31'b0, mem_if.mem_req_valid}, 32'd0);
            if (mem_if.mem_req_valid) begin
                check("one_outstanding", {31'b0, outstanding}, 32'd0);
                check("addr_aligned", {30'b0, mem_if.mem_addr[1:0]}, 32'd0);
                if (mem_if.mem_req_ready) begin
                    outstanding = 1'b1;
                    out_addr    = mem_if.mem_addr;
                    delay       = $urandom_range(0, 2);
                end
            end
            if (!inst_valid) check("nop_when_idle", instruction, NOP);
            if (rdy_in && inst_valid && !stall_in && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("sb_inst_pc", inst_pc, e);
                    check("sb_instruction", instruction, mem_word(e));
                    exp_q.push_back(e + 32'd4);
                    consumed++;
                end
            end
        end
    end

    initial begin
        rst                   = 1'b0;
        rdy_in                = 1'b1;
        redirect_valid        = 1'b0;
        redirect_pc           = '0;
        stall_in              = 1'b0;
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_rdata      = '0;

        // Reset state
        cyc(); cyc(); smp();
        check("rst_req_valid", {31'b0, mem_if.mem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_instruction", instruction, NOP);
        check("rst_inst_pc", inst_pc, 32'd0);
        cyc();
        rst = 1'b1;
        smp();
        check("idle_no_req", {31'b0, mem_if.mem_req_valid}, 32'd0);

        // Basic fetch with a one-cycle response
        cyc();
        mem_if.mem_req_ready = 1'b1;
        smp();
        check("first_req_valid", {31'b0, mem_if.mem_req_valid}, 32'd1);
        check("first_addr", mem_if.mem_addr, 32'h0);
        cyc();
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_rdata      = 32'h0050_0093;
        smp();
        check("wait_no_req", {31'b0, mem_if.mem_req_valid}, 32'd0);
        check("wait_not_valid", {31'b0, inst_valid}, 32'd0);
        cyc();
        mem_if.mem_resp_valid = 1'b0;
        smp();
        check("fetch_valid", {31'b0, inst_valid}, 32'd1);
        check("fetch_instr", instruction, 32'h0050_0093);
        check("fetch_pc", inst_pc, 32'h0);
        cyc(); smp();
        check("second_addr", mem_if.mem_addr, 32'h4);
        check("second_req", {31'b0, mem_if.mem_req_valid}, 32'd1);

        // Stall held for three cycles in HOLD
        mem_if.mem_req_ready = 1'b1;
        cyc();
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_rdata      = 32'h1111_1111;
        stall_in              = 1'b1;
        cyc();
        mem_if.mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            check("stall_valid", {31'b0, inst_valid}, 32'd1);
            check("stall_instr", instruction, 32'h1111_1111);
            check("stall_pc", inst_pc, 32'h4);
            check("stall_no_req", {31'b0, mem_if.mem_req_valid}, 32'd0);
            cyc();
        end
        stall_in = 1'b0;
        smp();
        check("unstall_still_valid", {31'b0, inst_valid}, 32'd1);
        cyc(); smp();
        check("after_stall_req", {31'b0, mem_if.mem_req_valid}, 32'd1);
        check("after_stall_addr", mem_if.mem_addr, 32'h8);
        check("after_stall_nop", instruction, NOP);

        // Redirect during WAIT drops the late response
        mem_if.mem_req_ready = 1'b1;
        cyc();
        mem_if.mem_req_ready = 1'b0;
        redirect_valid       = 1'b1;
        redirect_pc          = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_rdata      = 32'h2222_2222;
        smp();
        check("drop_not_valid", {31'b0, inst_valid}, 32'd0);
        cyc();
        mem_if.mem_resp_valid = 1'b0;
        smp();
        check("drop_still_invalid", {31'b0, inst_valid}, 32'd0);
        check("redirect_req", {31'b0, mem_if.mem_req_valid}, 32'd1);
        check("redirect_addr", mem_if.mem_addr, 32'h100);

        // PC wrap and redirect alignment
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        smp();
        check("top_addr", mem_if.mem_addr, 32'hFFFF_FFFC);
        mem_if.mem_req_ready = 1'b1;
        cyc();
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_rdata      = 32'h3333_3333;
        cyc();
        mem_if.mem_resp_valid = 1'b0;
        smp();
        check("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
        check("top_instr", instruction, 32'h3333_3333);
        cyc(); smp();
        check("wrap_addr", mem_if.mem_addr, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        cyc();
        redirect_valid = 1'b0;
        smp();
        check("aligned_redirect", mem_if.mem_addr, 32'h100);

        // Global freeze in REQ
        rdy_in               = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(); smp();
            check("freeze_no_req", {31'b0, mem_if.mem_req_valid}, 32'd0);
            check("freeze_addr", mem_if.mem_addr, 32'h100);
        end
        rdy_in               = 1'b1;
        mem_if.mem_req_ready = 1'b0;
        cyc(); smp();
        check("resume_req", {31'b0, mem_if.mem_req_valid}, 32'd1);
        check("resume_addr", mem_if.mem_addr, 32'h100);

        // Reset in the middle of WAIT; a response in IDLE is ignored
        mem_if.mem_req_ready = 1'b1;
        cyc();
        mem_if.mem_req_ready = 1'b0;
        rst                  = 1'b0;
        cyc(); smp();
        check("midrst_valid", {31'b0, inst_valid}, 32'd0);
        check("midrst_instr", instruction, NOP);
        check("midrst_no_req", {31'b0, mem_if.mem_req_valid}, 32'd0);
        rst                   = 1'b1;
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_rdata      = 32'hBAD0_BAD0;
        cyc();
        mem_if.mem_resp_valid = 1'b0;
        smp();
        check("post_rst_req", {31'b0, mem_if.mem_req_valid}, 32'd1);
        check("post_rst_addr", mem_if.mem_addr, 32'h0);
        check("post_rst_valid", {31'b0, inst_valid}, 32'd0);
        check("post_rst_instr", instruction, NOP);

        // Randomized traffic
        exp_q.delete();
        exp_q.push_back(32'h0);
        outstanding = 1'b0;
        random_mode = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            cyc();
            rdy_in                = ($urandom % 10) != 0;
            mem_if.mem_req_ready  = ($urandom % 10) < 6;
            stall_in              = ($urandom % 10) < 3;
            redirect_valid        = ($urandom % 16) == 0;
            redirect_pc           = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16))
                                                           : ($urandom & 32'h0000_0FFF);
            mem_if.mem_resp_valid = 1'b0;
            if (outstanding && rdy_in) begin
                if (delay == 0) begin
                    mem_if.mem_resp_valid = 1'b1;
                    mem_if.mem_rdata      = mem_word(out_addr);
                    outstanding           = 1'b0;
                end else begin
                    delay--;
                end
            end
            if (redirect_valid && rdy_in) begin
                exp_q.delete();
                exp_q.push_back(redirect_pc & 32'hFFFF_FFFC);
            end
        end
        random_mode = 1'b0;
        smp();
        check("progress", {31'b0, consumed > 50}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter LEN, default 32: datapath width of PC and instruction.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 mem_req_valid  output  1  fetch request to instruction memory.
REQ-007 mem_req_ready  input  1  memory accepts request this cycle.
REQ-008 mem_addr  output  LEN  fetch address, equal to internal pc.
REQ-009 mem_resp_valid  input  1  one-cycle pulse, read data valid.
REQ-010 mem_rdata  input  LEN  fetched instruction word.
REQ-011 redirect_valid  input  1  taken branch/jump resolved downstream.
REQ-012 redirect_pc  input  LEN  new fetch target.
REQ-013 stall_in  input  1  decode stage cannot accept an instruction.
REQ-014 inst_valid  output  1  instruction/inst_pc valid toward decoder.
REQ-015 instruction  output  LEN  registered instruction word.
REQ-016 inst_pc  output  LEN  address the instruction was fetched from.

Function
REQ-017 States IDLE, REQ, WAIT, HOLD, DROP, with exactly one request outstanding at any time.
REQ-018 IDLE: outputs idle; next cycle -> REQ.
REQ-019 REQ: mem_req_valid=1, mem_addr=pc; on mem_req_ready -> WAIT; otherwise stay in REQ.
REQ-020 REQ with redirect_valid: pc<=redirect_pc; if mem_req_ready in the same cycle -> DROP, else stay in REQ.
REQ-021 WAIT: mem_req_valid=0; on mem_resp_valid without redirect: instruction<=mem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, -> HOLD.
REQ-022 WAIT with redirect_valid: pc<=redirect_pc; if mem_resp_valid in the same cycle, discard data and -> REQ, else -> DROP.
REQ-023 DROP: discard the next mem_resp_valid, then -> REQ; a redirect in DROP updates pc and stays in DROP.
REQ-024 HOLD: inst_valid=1 and outputs stable; !stall_in -> inst_valid<=0, -> REQ; stall_in -> stay in HOLD.
REQ-025 HOLD with redirect_valid (priority over stall_in): inst_valid<=0, instruction<=NOP, pc<=redirect_pc, -> REQ.
REQ-026 Minimum latency: request accepted in cycle N, response in N+k, inst_valid high in N+k+1.
REQ-027 pc+4 wraps modulo 2^LEN; pc[1:0] and redirect_pc[1:0] forced to 2'b00.
REQ-028 rdy_in=0: all registers hold and mem_req_valid=0; mem_resp_valid while rdy_in=0 is illegal (assertion).
REQ-029 instruction shows NOP (32'h0000_0013) whenever inst_valid=0 after reset or flush.

Reset
REQ-030 rst=0 at a rising edge: state<=IDLE, pc<=RESET_PC, inst_valid<=0, instruction<=NOP, inst_pc<=0.
REQ-031 Reset overrides rdy_in, redirect_valid and any in-flight response; a response arriving after reset release while in IDLE is ignored.
REQ-032 mem_req_valid=0 during reset and in the first cycle after release.

Structure
REQ-033 State encodings, the NOP constant and the default RESET_PC live in the shared defines file.
REQ-034 One sub-module pc_register holds pc and applies the priority reset > redirect > increment.
REQ-035 FSM and output registers are in instruction_fetch, targeting 120-400 lines.

Verification
REQ-036 Reset, memory ready with 1-cycle response 0x00500093, no stall -> mem_addr=0; inst_valid 2 cycles after accept, inst_pc=0; next mem_addr=4.
REQ-037 stall_in held high 3 cycles in HOLD -> instruction/inst_pc stable; no mem_req_valid until stall drops.
REQ-038 redirect_valid with redirect_pc=0x100 during WAIT, response 2 cycles later -> response dropped, inst_valid stays 0, next mem_addr=0x100.
REQ-039 pc=0xFFFF_FFFC fetched -> next mem_addr=0x0000_0000; redirect_pc=0x103 -> mem_addr=0x100.
REQ-040 rdy_in low for 4 cycles in REQ -> mem_req_valid=0 and state/pc unchanged; resumes same address.
REQ-041 rst low mid-WAIT -> next cycle inst_valid=0, instruction=0x00000013; first request after release targets RESET_PC.
